instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage directly upstream of the instruction decoder/controller. It owns the PC and issues word reads to instruction memory over a ready handshake. It holds each returned word in an instruction register and presents it to decode as opcode[31:26] and func[5:0] together with its PC. It handles branch/jump redirects, including one in flight against an outstanding memory request, and a sticky halt on SYSCALL.

Parameters:
RESET_PC, 32'h0000_0000, address of first fetch after reset (word aligned)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_b  input  1  synchronous active-low reset
imem_req  output  1  read request to instruction memory
imem_addr  output  32  word address of request; low 2 bits always 0
imem_ready  input  1  memory completes request this cycle; imem_rdata valid
imem_rdata  input  32  instruction word returned
inst_valid  output  1  instruction/pc outputs hold a fetched instruction
instruction  output  32  instruction register
opcode  output  6  instruction[31:26]
func  output  6  instruction[5:0]
pc  output  32  address of held instruction
pc_plus4  output  32  pc + 4 (mod 2^32)
inst_accept  input  1  decode consumes held instruction (qualified by inst_valid)
redirect  input  1  branch taken / jump / jr: next fetch from redirect_target
redirect_target  input  32  new PC
halt  input  1  held instruction is SYSCALL; sampled with inst_accept
halted  output  1  fetch stopped until reset
misaligned  output  1  sticky: a redirect_target had nonzero bits [1:0]

Behaviour:
- Reset (rst_b=0 at edge): state=S_REQ, fetch_pc=RESET_PC, drop=0. inst_valid=0, instruction=0, opcode=0, func=0, pc=RESET_PC, pc_plus4=RESET_PC+4, halted=0, misaligned=0. imem_req is combinational from state and is 0 while rst_b=0. Reset mid-request abandons it; a stale imem_ready in the first post-reset cycle is taken as the response to the new request.
- imem_req=1 only in S_REQ, and imem_addr=fetch_pc. Address is stable while imem_req=1 and imem_ready=0; a redirect never changes imem_addr mid-request.
- States:
  - S_REQ, imem_ready=0: hold.
  - S_REQ, imem_ready=1, drop=0: instruction<=imem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+4, inst_valid<=1, go to S_VALID.
  - S_REQ, imem_ready=1, drop=1: discard the data, drop<=0, stay in S_REQ (new addr next cycle).
  - S_REQ, redirect=1: fetch_pc<=target, with the same-cycle fetch_pc+4 update overridden. If imem_ready=0, drop<=1. If imem_ready=1, discard the word and stay in S_REQ.
  - S_VALID, redirect=1 (priority over accept): inst_valid<=0, fetch_pc<=target, go to S_REQ.
  - S_VALID, inst_accept=1, halt=1: inst_valid<=0, halted<=1, go to S_HALT.
  - S_VALID, inst_accept=1, halt=0: inst_valid<=0, go to S_REQ.
  - S_VALID otherwise: hold all outputs stable.
  - S_HALT: imem_req=0; redirect and inst_accept ignored; exit only by reset.
- Redirect target handling: target[1:0] is forced to 00; misaligned<=1 if target[1:0]!=0. misaligned clears only on reset.
- Latency: request at cycle N with imem_ready at N gives inst_valid=1 at N+1. Throughput is at most one instruction per 2 cycles (request, present/accept).
- fetch_pc and pc_plus4 wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- opcode and func are continuous slices of instruction.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory (imem_ready tied 1), inst_accept tied 1 -> imem_addr sequence 0,4,8,C on alternating cycles; pc/instruction match memory; inst_valid pulses every 2nd cycle.
- Hold: inst_accept=0 for 5 cycles with word 32'h0109_5020 held -> inst_valid, instruction, opcode=6'h00, func=6'h20 and pc stable; imem_req=0 throughout.
- Redirect during a 3-cycle wait at addr 0x10, target 0x40 -> imem_addr stays 0x10 until ready; that word is dropped (inst_valid stays 0); next request is at 0x40 and delivers pc=0x40.
- Redirect and inst_accept in the same S_VALID cycle, target 0x103 -> redirect wins; next imem_addr=0x100; misaligned=1 and stays 1 after further fetches.
- SYSCALL accepted with halt=1 -> halted=1 next cycle; imem_req stays 0 for 20 cycles despite redirect pulses; rst_b=0 for one cycle -> halted=0 and fetch restarts at RESET_PC.
- Wrap: redirect to 0xFFFF_FFFC -> pc=0xFFFF_FFFC, pc_plus4=0, next imem_addr=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory, holds the returned word for decode, and handles redirects and halt.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        inst_accept,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        halted,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        mis_q, mis_d;

  logic [31:0] tgt_aligned;
  logic        tgt_mis;

  assign tgt_aligned = {redirect_target[31:2], 2'b00};
  assign tgt_mis     = |redirect_target[1:0];

  // While a redirected request is still outstanding, keep presenting the
  // address that was originally requested; fetch_pc already holds the target.
  assign imem_req    = rst_b & (state_q == S_REQ);
  assign imem_addr   = drop_q ? hold_addr_q : fetch_pc_q;
  assign inst_valid  = valid_q;
  assign instruction = instr_q;
  assign opcode      = instr_q[31:26];
  assign func        = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign halted      = halted_q;
  assign misaligned  = mis_q;

  // Next-state logic: request / present / halt sequencing with redirects.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    drop_d      = drop_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    halted_d    = halted_q;
    mis_d       = mis_q;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          fetch_pc_d = tgt_aligned;
          mis_d      = mis_q | tgt_mis;
          if (!imem_ready) begin
            drop_d = 1'b1;
            if (!drop_q) begin
              hold_addr_d = fetch_pc_q;
            end
          end else begin
            drop_d = 1'b0;
          end
        end else if (imem_ready) begin
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            instr_d    = imem_rdata;
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            valid_d    = 1'b1;
            state_d    = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (redirect) begin
          valid_d    = 1'b0;
          fetch_pc_d = tgt_aligned;
          mis_d      = mis_q | tgt_mis;
          state_d    = S_REQ;
        end else if (inst_accept) begin
          valid_d = 1'b0;
          if (halt) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= RESET_PC;
      drop_q      <= 1'b0;
      valid_q     <= 1'b0;
      instr_q     <= 32'h0;
      pc_q        <= RESET_PC;
      halted_q    <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
      drop_q      <= drop_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      halted_q    <= halted_d;
      mis_q       <= mis_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios with literal checks,
// plus a transaction-level model compared against the DUT every cycle.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_b;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_accept;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt;
  logic        halted;
  logic        misaligned;

  int testsRun;
  int testsFailed;
  bit checkEn;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .instruction     (instruction),
    .opcode          (opcode),
    .func            (func),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .inst_accept     (inst_accept),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .halted          (halted),
    .misaligned      (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: one R-type add at 0x40, lw-like words elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h0109_5020;
    return 32'h8C00_0000 | {16'h0, a[15:0]};
  endfunction

  assign imem_rdata = memWord(imem_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstB, input logic ready, input logic accept,
                               input logic redir, input logic [31:0] target,
                               input logic haltIn);
    #1;
    rst_b           = rstB;
    imem_ready      = ready;
    inst_accept     = accept;
    redirect        = redir;
    redirect_target = target;
    halt            = haltIn;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input int budget);
    int n;
    n = 0;
    while (inst_valid !== 1'b1 && n < budget) begin
      nextEdge();
      n++;
    end
    checkOutput("wait_inst_valid", 32'(inst_valid), 32'd1);
  endtask

  // Transaction-level view: the fetch unit either has a word on offer, has
  // stopped, or is requesting mReqAddr; a redirect while a request is
  // outstanding marks that response for discard and remembers the target.
  logic        mValid, mHalted, mMis, mDiscard;
  logic [31:0] mInstr, mPc, mReqAddr, mRedirAddr;

  always @(posedge clk) begin
    logic [31:0] tgt;
    tgt = {redirect_target[31:2], 2'b00};
    if (!rst_b) begin
      mValid = 0; mHalted = 0; mMis = 0; mDiscard = 0;
      mInstr = 0; mPc = 0; mReqAddr = 0; mRedirAddr = 0;
    end else if (mHalted) begin
      // stopped until reset
    end else if (!mValid) begin
      if (redirect) begin
        if (redirect_target[1:0] != 2'b00) mMis = 1;
        if (imem_ready) begin
          mReqAddr = tgt;
          mDiscard = 0;
        end else begin
          mRedirAddr = tgt;
          mDiscard   = 1;
        end
      end else if (imem_ready) begin
        if (mDiscard) begin
          mReqAddr = mRedirAddr;
          mDiscard = 0;
        end else begin
          mValid   = 1;
          mInstr   = memWord(mReqAddr);
          mPc      = mReqAddr;
          mReqAddr = mReqAddr + 32'd4;
        end
      end
    end else begin
      if (redirect) begin
        if (redirect_target[1:0] != 2'b00) mMis = 1;
        mValid   = 0;
        mReqAddr = tgt;
      end else if (inst_accept) begin
        mValid = 0;
        if (halt) mHalted = 1;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, on the falling edge.
  always @(negedge clk) begin
    logic expReq;
    if (checkEn) begin
      expReq = rst_b && !mValid && !mHalted;
      checkOutput("m_imem_req", 32'(imem_req), 32'(expReq));
      if (expReq) checkOutput("m_imem_addr", imem_addr, mReqAddr);
      checkOutput("m_inst_valid", 32'(inst_valid), 32'(mValid));
      checkOutput("m_instruction", instruction, mInstr);
      checkOutput("m_opcode", 32'(opcode), 32'(mInstr[31:26]));
      checkOutput("m_func", 32'(func), 32'(mInstr[5:0]));
      checkOutput("m_pc", pc, mPc);
      checkOutput("m_pc_plus4", pc_plus4, mPc + 32'd4);
      checkOutput("m_halted", 32'(halted), 32'(mHalted));
      checkOutput("m_misaligned", 32'(misaligned), 32'(mMis));
    end
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    checkEn     = 0;
    rst_b = 0; imem_ready = 0; inst_accept = 0; redirect = 0;
    redirect_target = 32'h0; halt = 0;

    // Reset state
    nextEdge();
    checkEn = 1;
    nextEdge();
    checkOutput("reset_req", 32'(imem_req), 32'd0);
    checkOutput("reset_valid", 32'(inst_valid), 32'd0);
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_pc_plus4", pc_plus4, 32'h4);
    checkOutput("reset_instruction", instruction, 32'h0);

    // Zero-wait memory with accept tied high: 0,4,8,C on alternating cycles
    applyStimulus(1, 1, 1, 0, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      nextEdge();
      checkOutput("stream_valid", 32'(inst_valid), 32'd1);
      checkOutput("stream_pc", pc, 32'(4 * k));
      checkOutput("stream_instr", instruction, 32'h8C00_0000 | 32'(4 * k));
      nextEdge();
      checkOutput("stream_gap_valid", 32'(inst_valid), 32'd0);
      checkOutput("stream_addr", imem_addr, 32'(4 * (k + 1)));
    end

    // Redirect to 0x40 while the request at 0x10 waits for memory
    applyStimulus(1, 0, 0, 1, 32'h40, 0);
    nextEdge();
    checkOutput("wait_addr_0", imem_addr, 32'h10);
    applyStimulus(1, 0, 0, 0, 32'h0, 0);
    for (int i = 1; i < 3; i++) begin
      nextEdge();
      checkOutput("wait_addr", imem_addr, 32'h10);
      checkOutput("wait_valid", 32'(inst_valid), 32'd0);
    end
    applyStimulus(1, 1, 0, 0, 32'h0, 0);
    nextEdge();
    checkOutput("drop_valid", 32'(inst_valid), 32'd0);
    checkOutput("after_drop_addr", imem_addr, 32'h40);
    nextEdge();
    checkOutput("redir_pc", pc, 32'h40);

    // Hold the add instruction for five cycles without accept
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", 32'(inst_valid), 32'd1);
      checkOutput("hold_instr", instruction, 32'h0109_5020);
      checkOutput("hold_opcode", 32'(opcode), 32'h00);
      checkOutput("hold_func", 32'(func), 32'h20);
      checkOutput("hold_pc", pc, 32'h40);
      checkOutput("hold_req", 32'(imem_req), 32'd0);
      nextEdge();
    end

    // Redirect and accept together: redirect wins, misaligned target
    applyStimulus(1, 1, 1, 1, 32'h103, 0);
    nextEdge();
    checkOutput("redir_win_valid", 32'(inst_valid), 32'd0);
    checkOutput("redir_win_addr", imem_addr, 32'h100);
    checkOutput("misaligned_set", 32'(misaligned), 32'd1);
    applyStimulus(1, 1, 1, 0, 32'h0, 0);
    nextEdge();
    checkOutput("aligned_pc", pc, 32'h100);
    repeat (3) nextEdge();
    checkOutput("misaligned_sticky", 32'(misaligned), 32'd1);

    // SYSCALL halt, ignored redirects, recovery by reset
    applyStimulus(1, 1, 0, 0, 32'h0, 0);
    waitValid(10);
    applyStimulus(1, 1, 1, 0, 32'h0, 1);
    nextEdge();
    checkOutput("halted_set", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 1, i[0], 32'h300, 0);
      nextEdge();
      checkOutput("halt_req", 32'(imem_req), 32'd0);
    end
    applyStimulus(0, 1, 0, 0, 32'h0, 0);
    nextEdge();
    checkOutput("rst_req_low", 32'(imem_req), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_misaligned", 32'(misaligned), 32'd0);
    applyStimulus(1, 1, 0, 0, 32'h0, 0);
    #1;
    checkOutput("restart_req", 32'(imem_req), 32'd1);
    checkOutput("restart_addr", imem_addr, 32'h0);

    // Wrap at the top of the address space, then redirect in a ready cycle
    waitValid(10);
    applyStimulus(1, 1, 0, 1, 32'hFFFF_FFFC, 0);
    nextEdge();
    applyStimulus(1, 1, 0, 0, 32'h0, 0);
    nextEdge();
    checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc_plus4", pc_plus4, 32'h0);
    checkOutput("wrap_instr", instruction, 32'h8C00_FFFC);
    applyStimulus(1, 1, 1, 0, 32'h0, 0);
    nextEdge();
    checkOutput("wrap_next_addr", imem_addr, 32'h0);
    applyStimulus(1, 1, 0, 1, 32'h200, 0);
    nextEdge();
    checkOutput("ready_redir_valid", 32'(inst_valid), 32'd0);
    checkOutput("ready_redir_addr", imem_addr, 32'h200);
    applyStimulus(1, 1, 0, 0, 32'h0, 0);
    nextEdge();
    checkOutput("ready_redir_pc", pc, 32'h200);

    repeat (3) nextEdge();
    checkEn = 0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
